// File: rtl/pwm_mch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_mch
// Brief    : Multi-channel PWM with a shared period counter and double-buffered
//            period/threshold registers.
//            Optional up/down counting is enabled by the macro PWM_MCH_CENTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_mch #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     aclr_n,
    input  logic                     sclr,
    input  logic                     en,
`ifdef PWM_MCH_CENTER_EN
    input  logic                     center,
`endif
    input  logic                     per_wr,
    input  logic [WIDTH-1:0]         per_din,
    input  logic                     t_wr,
    input  logic [CH_W-1:0]          t_ch,
    input  logic [1:0][WIDTH-1:0]    t_din,
    input  logic [CHANNELS-1:0]      inv,
    output logic                     load,
    output logic                     pend,
    output logic [CHANNELS-1:0]      q
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_per_act;
    logic [WIDTH-1:0]    r_per_sh;
    logic                r_per_pend;
    logic                r_pend;
    logic                w_xfer;
    logic                w_per_pend_nxt;
    logic [CHANNELS-1:0] w_t_pend_nxt;
    logic [WIDTH-1:0]    w_cnt_nxt;

`ifdef PWM_MCH_CENTER_EN
    logic r_ctr;
    logic r_dn;
    logic w_ctr;
    logic w_dn_nxt;

    // Counting mode only changes at the bottom of the count
    assign w_ctr = (r_cnt == '0) ? center : r_ctr;
    assign load  = en && (w_ctr ? ((r_dn && (r_cnt == '0)) || (r_per_act == '0))
                                : (r_cnt >= r_per_act));
`else
    assign load  = en && (r_cnt >= r_per_act);
`endif

    // Synchronous clear doubles as a forced shadow-to-active transfer
    assign w_xfer         = sclr || load;
    assign w_per_pend_nxt = per_wr || (r_per_pend && !w_xfer);
    assign pend           = r_pend;

    always_comb begin
        w_cnt_nxt = r_cnt;
`ifdef PWM_MCH_CENTER_EN
        w_dn_nxt  = r_dn;
`endif
        if (sclr) begin
            w_cnt_nxt = '0;
`ifdef PWM_MCH_CENTER_EN
            w_dn_nxt  = 1'b0;
`endif
        end else if (en) begin
`ifdef PWM_MCH_CENTER_EN
            if (w_ctr) begin
                if (r_per_act == '0) begin
                    w_cnt_nxt = '0;
                    w_dn_nxt  = 1'b0;
                end else if (r_dn) begin
                    if (r_cnt == '0) begin
                        w_cnt_nxt = c_one;
                        w_dn_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_one;
                    end
                end else if (r_cnt >= r_per_act) begin
                    w_cnt_nxt = r_cnt - c_one;
                    w_dn_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end else begin
                w_dn_nxt  = 1'b0;
                w_cnt_nxt = load ? '0 : (r_cnt + c_one);
            end
`else
            w_cnt_nxt = load ? '0 : (r_cnt + c_one);
`endif
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cnt      <= '0;
            r_per_act  <= '1;
            r_per_sh   <= '1;
            r_per_pend <= 1'b0;
            r_pend     <= 1'b0;
`ifdef PWM_MCH_CENTER_EN
            r_ctr      <= 1'b0;
            r_dn       <= 1'b0;
`endif
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_per_pend <= w_per_pend_nxt;
            r_pend     <= w_per_pend_nxt || (|w_t_pend_nxt);
            if (per_wr) begin
                r_per_sh <= per_din;
            end
            if (w_xfer && r_per_pend) begin
                r_per_act <= r_per_sh;
            end
`ifdef PWM_MCH_CENTER_EN
            r_ctr      <= w_ctr;
            r_dn       <= w_dn_nxt;
`endif
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_on_act;
        logic [WIDTH-1:0] r_off_act;
        logic [WIDTH-1:0] r_on_sh;
        logic [WIDTH-1:0] r_off_sh;
        logic             r_tp;
        logic             r_s;
        logic             w_wr;
        logic             w_hit;

        // Out-of-range channel indices never match, so such writes are dropped
        assign w_wr            = t_wr && (t_ch == CH_W'(i));
        assign w_t_pend_nxt[i] = w_wr || (r_tp && !w_xfer);

`ifdef PWM_MCH_CENTER_EN
        assign w_hit = w_ctr ? (r_cnt >= r_on_act)
                             : ((r_cnt >= r_on_act) && (r_cnt < r_off_act));
`else
        assign w_hit = (r_cnt >= r_on_act) && (r_cnt < r_off_act);
`endif

        always_ff @(posedge clk or negedge aclr_n) begin
            if (!aclr_n) begin
                r_on_act  <= '0;
                r_off_act <= '0;
                r_on_sh   <= '0;
                r_off_sh  <= '0;
                r_tp      <= 1'b0;
                r_s       <= 1'b0;
            end else begin
                r_tp <= w_t_pend_nxt[i];
                r_s  <= en && !sclr && w_hit;
                if (w_wr) begin
                    r_on_sh  <= t_din[0];
                    r_off_sh <= t_din[1];
                end
                if (w_xfer && r_tp) begin
                    r_on_act  <= r_on_sh;
                    r_off_act <= r_off_sh;
                end
            end
        end

        assign q[i] = r_s ^ inv[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_mch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_mch
// Brief    : Directed, table-driven bench for pwm_mch (WIDTH=8, CHANNELS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_mch;

    logic            clk = 1'b0;
    logic            aclr_n;
    logic            sclr;
    logic            en;
    logic            per_wr;
    logic [7:0]      per_din;
    logic            t_wr;
    logic [1:0]      t_ch;
    logic [1:0][7:0] t_din;
    logic [2:0]      inv;
    logic            load;
    logic            pend;
    logic [2:0]      q;
`ifdef PWM_MCH_CENTER_EN
    logic            center;
    int              exp_c [18] = '{0,1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0,1};
    int              exp_q [18] = '{0,0,0,1,1,1,1,1,0,0,0,1,1,1,1,1,0,0};
`endif

    int nvec  = 0;
    int nfail = 0;
    int n;

    typedef struct {
        logic       en;
        logic       sclr;
        logic       pw;
        logic [7:0] pd;
        logic       tw;
        logic [1:0] tch;
        logic [7:0] ton;
        logic [7:0] toff;
        logic       eld;
        logic       epd;
        logic [2:0] eq;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    pwm_mch #(.WIDTH(8), .CHANNELS(3)) dut (
        .clk     (clk),
        .aclr_n  (aclr_n),
        .sclr    (sclr),
        .en      (en),
`ifdef PWM_MCH_CENTER_EN
        .center  (center),
`endif
        .per_wr  (per_wr),
        .per_din (per_din),
        .t_wr    (t_wr),
        .t_ch    (t_ch),
        .t_din   (t_din),
        .inv     (inv),
        .load    (load),
        .pend    (pend),
        .q       (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic s, input logic pw, input logic [7:0] pd,
                       input logic tw, input logic [1:0] tch, input logic [7:0] ton,
                       input logic [7:0] toff, input logic eld, input logic epd,
                       input logic [2:0] eq, input logic [7:0] ecnt);
        vec_t v;
        v.en = e; v.sclr = s; v.pw = pw; v.pd = pd; v.tw = tw; v.tch = tch;
        v.ton = ton; v.toff = toff; v.eld = eld; v.epd = epd; v.eq = eq; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic eld, input logic epd, input logic [2:0] eq,
                        input logic [7:0] ecnt);
        add(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 8'd0, eld, epd, eq, ecnt);
    endtask

    initial begin
        aclr_n = 1'b0; sclr = 1'b0; en = 1'b0; per_wr = 1'b0; per_din = '0;
        t_wr = 1'b0; t_ch = '0; t_din = '0; inv = 3'b101;
`ifdef PWM_MCH_CENTER_EN
        center = 1'b0;
`endif

        // period 9, ch0 {2,5}; ch1 {0,4} written mid-period; period 3 written on a load cycle
        add(1'b0,1'b0,1'b0,8'd0, 1'b0,2'd0,8'd0,8'd0, 1'b0,1'b0,3'd0,8'd0);
        add(1'b0,1'b0,1'b1,8'd9, 1'b0,2'd0,8'd0,8'd0, 1'b0,1'b0,3'd0,8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 1'b1,2'd0,8'd2,8'd5, 1'b0,1'b1,3'd0,8'd0);
        add(1'b1,1'b1,1'b0,8'd0, 1'b0,2'd0,8'd0,8'd0, 1'b0,1'b1,3'd0,8'd0);
        idle(0,0,3'd0,8'd0); idle(0,0,3'd0,8'd1); idle(0,0,3'd0,8'd2);
        idle(0,0,3'd1,8'd3); idle(0,0,3'd1,8'd4); idle(0,0,3'd1,8'd5);
        add(1'b1,1'b0,1'b0,8'd0, 1'b1,2'd1,8'd0,8'd4, 1'b0,1'b0,3'd0,8'd6);
        idle(0,1,3'd0,8'd7); idle(0,1,3'd0,8'd8); idle(1,1,3'd0,8'd9);
        idle(0,0,3'd0,8'd0); idle(0,0,3'd2,8'd1); idle(0,0,3'd2,8'd2);
        idle(0,0,3'd3,8'd3); idle(0,0,3'd3,8'd4); idle(0,0,3'd1,8'd5);
        idle(0,0,3'd0,8'd6); idle(0,0,3'd0,8'd7); idle(0,0,3'd0,8'd8);
        add(1'b1,1'b0,1'b1,8'd3, 1'b0,2'd0,8'd0,8'd0, 1'b1,1'b0,3'd0,8'd9);
        idle(0,1,3'd0,8'd0); idle(0,1,3'd2,8'd1); idle(0,1,3'd2,8'd2);
        idle(0,1,3'd3,8'd3); idle(0,1,3'd3,8'd4); idle(0,1,3'd1,8'd5);
        idle(0,1,3'd0,8'd6); idle(0,1,3'd0,8'd7); idle(0,1,3'd0,8'd8);
        idle(1,1,3'd0,8'd9);
        idle(0,0,3'd0,8'd0); idle(0,0,3'd2,8'd1); idle(0,0,3'd2,8'd2);
        idle(1,0,3'd3,8'd3); idle(0,0,3'd3,8'd0); idle(0,0,3'd2,8'd1);

        #12;
        chk("reset_state", {load, pend, q, dut.r_cnt}, {1'b0, 1'b0, 3'b101, 8'd0});
        @(negedge clk);
        inv = 3'b000;
        aclr_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            en = tbl[i].en; sclr = tbl[i].sclr; per_wr = tbl[i].pw; per_din = tbl[i].pd;
            t_wr = tbl[i].tw; t_ch = tbl[i].tch; t_din = {tbl[i].toff, tbl[i].ton};
            #2;
            chk($sformatf("vec%0d {load,pend,q,cnt}", i), {load, pend, q, dut.r_cnt},
                {tbl[i].eld, tbl[i].epd, tbl[i].eq, tbl[i].ecnt});
        end

        // Period 0: load every cycle, ch0 {0,1} always on, ch1 {5,5} never on
        @(negedge clk);
        en = 1'b0; per_wr = 1'b1; per_din = 8'd0; t_wr = 1'b1; t_ch = 2'd0; t_din = {8'd1, 8'd0};
        @(negedge clk);
        per_wr = 1'b0; t_ch = 2'd1; t_din = {8'd5, 8'd5};
        @(negedge clk);
        t_wr = 1'b0; sclr = 1'b1; en = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        #2 chk("per0_first {load,cnt,q}", {load, dut.r_cnt, q}, {1'b1, 8'd0, 3'b000});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2 chk("per0_run {load,cnt,q}", {load, dut.r_cnt, q}, {1'b1, 8'd0, 3'b001});
        end
        @(negedge clk);
        inv = 3'b100;
        #2 chk("inv_immediate {load,q}", {load, q}, {1'b1, 3'b101});

        // en dropped for 7 cycles at cnt=4
        @(negedge clk);
        inv = 3'b000; en = 1'b0; per_wr = 1'b1; per_din = 8'd9;
        t_wr = 1'b1; t_ch = 2'd0; t_din = {8'd9, 8'd0};
        @(negedge clk);
        per_wr = 1'b0; t_wr = 1'b0; sclr = 1'b1; en = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        #2 chk("en_drop {load,cnt,q}", {load, dut.r_cnt, q}, {1'b0, 8'd4, 3'b001});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #2 chk("en_low {load,pend,cnt,q}", {load, pend, dut.r_cnt, q},
                   {1'b0, 1'b0, 8'd4, 3'b000});
        end
        @(negedge clk);
        en = 1'b1;
        #2 chk("en_resume0 {cnt,q}", {dut.r_cnt, q}, {8'd4, 3'b000});
        @(negedge clk);
        #2 chk("en_resume1 {cnt,q}", {dut.r_cnt, q}, {8'd5, 3'b001});
        @(negedge clk);
        #2 chk("en_resume2 {cnt,q}", {dut.r_cnt, q}, {8'd6, 3'b001});

        // Out-of-range channel write is dropped; an in-range one sets pend
        @(negedge clk);
        t_wr = 1'b1; t_ch = 2'd3; t_din = {8'd2, 8'd1};
        @(negedge clk);
        t_wr = 1'b0;
        #2 chk("bad_ch_pend", {31'd0, pend}, 32'd0);
        @(negedge clk);
        t_wr = 1'b1; t_ch = 2'd2; t_din = {8'd0, 8'd0};
        @(negedge clk);
        t_wr = 1'b0;
        #2 chk("good_ch_pend", {31'd0, pend}, 32'd1);

        // Asynchronous reset mid-period drops the pending period write
        @(negedge clk);
        inv = 3'b010; per_wr = 1'b1; per_din = 8'd2;
        @(negedge clk);
        per_wr = 1'b0;
        #1 aclr_n = 1'b0;
        #1 chk("aclr {load,pend,cnt,q}", {load, pend, dut.r_cnt, q},
               {1'b0, 1'b0, 8'd0, 3'b010});
        @(negedge clk);
        aclr_n = 1'b1; en = 1'b1;
        #1 chk("aclr_pend_after", {31'd0, pend}, 32'd0);
        #1;
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            if (load) begin
                n = k;
                break;
            end
            @(negedge clk);
            #2;
        end
        chk("aclr_full_period_cycles", n, 256);
        chk("aclr_q_run", {29'd0, q}, {29'd0, 3'b010});

`ifdef PWM_MCH_CENTER_EN
        // Up/down counting: per=4, ch0 on at 2, off threshold ignored
        @(negedge clk);
        inv = 3'b000; en = 1'b0; center = 1'b1; per_wr = 1'b1; per_din = 8'd4;
        t_wr = 1'b1; t_ch = 2'd0; t_din = {8'd0, 8'd2};
        @(negedge clk);
        per_wr = 1'b0; t_wr = 1'b0; sclr = 1'b1; en = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        for (int k = 0; k < 18; k++) begin
            #2;
            chk($sformatf("ctr%0d {load,cnt,q0}", k), {load, dut.r_cnt, q[0]},
                {((k == 8) || (k == 16)) ? 1'b1 : 1'b0, exp_c[k][7:0], exp_q[k][0]});
            @(negedge clk);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
